// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one instruction word at a time, holds it for the
// control unit until it retires, then advances or redirects the program counter.
module fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid,
  output logic [15:0]       inst,
  output logic              inst_valid,
  input  logic              done,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       retired,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_ISSUE = 2'b10,
    S_ERROR = 2'b11
  } state_t;

  // Wait count that, once reached by the increment, declares a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  logic [7:0]        r_wait;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_inst;
  logic              r_inst_valid;
  logic              r_mem_rd;
  logic [15:0]       r_retired;
  logic              r_err;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_ret_sat;

  assign w_next_pc  = jump_en ? jump_addr : (r_pc + ADDR_W'(1));
  assign w_ret_sat  = (r_retired == 16'hFFFF);

  assign mem_addr   = r_pc;
  assign mem_rd     = r_mem_rd;
  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign pc         = r_pc;
  assign retired    = r_retired;
  assign err        = r_err;

  // Fetch/issue state machine; mem_rd and inst_valid are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_wait       <= 8'd0;
      r_pc         <= '0;
      r_inst       <= 16'h0000;
      r_inst_valid <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_retired    <= 16'h0000;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state  <= S_FETCH;
            r_mem_rd <= 1'b1;
            r_wait   <= 8'd0;
          end else begin
            r_state  <= S_IDLE;
            r_mem_rd <= 1'b0;
          end
          r_inst_valid <= 1'b0;
        end
        S_FETCH: begin
          if (mem_valid) begin
            r_inst       <= mem_rdata;
            r_inst_valid <= 1'b1;
            r_mem_rd     <= 1'b0;
            r_state      <= S_ISSUE;
          end else if (r_wait == WAIT_LAST) begin
            r_err    <= 1'b1;
            r_mem_rd <= 1'b0;
            r_state  <= S_ERROR;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_ISSUE: begin
          // Run is only consulted at retirement so an issued instruction always completes.
          if (done) begin
            r_pc         <= w_next_pc;
            r_retired    <= w_ret_sat ? r_retired : (r_retired + 16'd1);
            r_inst_valid <= 1'b0;
            if (run) begin
              r_state  <= S_FETCH;
              r_mem_rd <= 1'b1;
              r_wait   <= 8'd0;
            end else begin
              r_state  <= S_IDLE;
              r_mem_rd <= 1'b0;
            end
          end else begin
            r_inst_valid <= 1'b1;
          end
        end
        S_ERROR: begin
          r_mem_rd     <= 1'b0;
          r_inst_valid <= 1'b0;
          r_err        <= 1'b1;
        end
        default: begin
          r_state      <= S_IDLE;
          r_mem_rd     <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning program-counter and memory-address width.
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of wait cycles for mem_valid before an error (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port run, input, 1 bit: permits fetching while high.
REQ-006 SHALL have port mem_addr, output, ADDR_W bits: instruction memory address.
REQ-007 SHALL have port mem_rd, output, 1 bit: memory read request.
REQ-008 SHALL have port mem_rdata, input, 16 bits: instruction word from memory.
REQ-009 SHALL have port mem_valid, input, 1 bit: mem_rdata is valid this cycle.
REQ-010 SHALL have port inst, output, 16 bits: the instruction presented to the control unit.
REQ-011 SHALL have port inst_valid, output, 1 bit: inst is held for execution.
REQ-012 SHALL have port done, input, 1 bit: single-cycle pulse from the control unit meaning the instruction has retired.
REQ-013 SHALL have port jump_en, input, 1 bit: redirect request, sampled only together with done.
REQ-014 SHALL have port jump_addr, input, ADDR_W bits: redirect target.
REQ-015 SHALL have port pc, output, ADDR_W bits: address of the current instruction.
REQ-016 SHALL have port retired, output, 16 bits: count of retired instructions.
REQ-017 SHALL have port err, output, 1 bit: sticky memory-timeout flag.

Function
REQ-018 SHALL implement four states: IDLE, FETCH, ISSUE and ERROR.
REQ-019 In IDLE, SHALL move to FETCH on the next edge when run=1, and SHALL otherwise stay in IDLE.
REQ-020 In FETCH, SHALL drive mem_rd=1 and mem_addr=pc, and SHALL clear the wait counter on entry.
REQ-021 In FETCH with mem_valid=1, SHALL register mem_rdata into inst and go to ISSUE on the same edge.
REQ-022 In FETCH with mem_valid=0, SHALL increment the wait counter; when the counter reaches TIMEOUT without mem_valid, it SHALL set err=1 and go to ERROR.
REQ-023 SHALL ignore mem_valid in every state other than FETCH.
REQ-024 In ISSUE, SHALL drive inst_valid=1 and hold inst constant until done is seen.
REQ-025 In ISSUE with done=1, when jump_en=1 SHALL set pc<=jump_addr; otherwise SHALL set pc<=pc+1, wrapping modulo 2^ADDR_W.
REQ-026 In ISSUE with done=1, SHALL increment retired, saturating at 16'hFFFF.
REQ-027 In ISSUE with done=1, SHALL go to FETCH if run=1, and to IDLE otherwise.
REQ-028 SHALL not abort an instruction already in ISSUE when run falls; the instruction completes first.
REQ-029 SHALL ignore done outside ISSUE: pc, retired and state are unchanged.
REQ-030 SHALL give a minimum issue-to-next-fetch latency of 1 cycle: the mem_rd for pc+1 appears the cycle after the done edge.
REQ-031 In ERROR, SHALL hold mem_rd=0 and inst_valid=0 and keep err=1 until reset; run has no effect.
REQ-032 SHALL keep mem_rd=0 in every state except FETCH.
REQ-033 SHALL keep inst_valid=0 in every state except ISSUE.

Reset
REQ-034 On reset=0, SHALL immediately and without a clock set: state=IDLE, pc=0, inst=16'h0000, inst_valid=0, mem_rd=0, retired=0, err=0, wait counter=0.
REQ-035 Reset asserted in mid-FETCH or mid-ISSUE SHALL discard the in-flight instruction; there is no completion.
REQ-036 After reset release, SHALL start operation at the first rising edge of clk on which run=1.

Verification
REQ-037 Basic fetch: reset, run=1, memory returns 16'hA5C3 after 2 cycles -> mem_addr=0; inst=16'hA5C3 with inst_valid=1; done pulse -> pc=1, retired=1, next mem_rd at address 1.
REQ-038 Jump: done=1 with jump_en=1 and jump_addr=8'h40 -> pc=8'h40 and the next fetch is at 8'h40.
REQ-039 PC wrap: pc=8'hFF, done with jump_en=0 -> pc=8'h00.
REQ-040 Timeout: mem_valid held low for 15 cycles in FETCH -> err=1, mem_rd=0; err holds until reset=0, then all outputs return to their reset values.
REQ-041 Run drop and stray done: run=0 during ISSUE -> instruction completes on done, then IDLE with mem_rd=0; a done pulse in IDLE -> pc and retired unchanged.
REQ-042 Async reset mid-ISSUE: reset=0 between clock edges -> inst_valid=0 and pc=0 before the next edge, with no retirement.
